// File: rtl/stall_ctrl.sv
// Pipeline stall/flush sequencer: times hazard stalls,
// squashes IF/ID on ID mispredicts, counts stall/flush events.
module stall_ctrl #(
  parameter int BR_LOAD_STALLS = 2,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_stall,
  input  logic [1:0]       br_stall,
  input  logic             br_mispredict,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             redirect_valid,
  output logic             hold_active,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

  localparam bit HAS_HOLD = (BR_LOAD_STALLS > 1);
  localparam logic [2:0] HLOAD =
    3'(HAS_HOLD ? BR_LOAD_STALLS - 2 : 0);

  state_t     state, state_n;
  logic [2:0] hcnt, hcnt_n;
  logic       stall_now;

  // State and hold counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      hcnt  <= '0;
    end else begin
      state <= state_n;
      hcnt  <= hcnt_n;
    end
  end

  // Next state: hazards are ignored while holding,
  // the detector only sees the bubble then
  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    case (state)
      RUN: begin
        if (br_stall[1] && HAS_HOLD) begin
          state_n = HOLD;
          hcnt_n  = HLOAD;
        end
      end
      HOLD: begin
        if (hcnt == 3'd0) state_n = RUN;
        else hcnt_n = hcnt - 3'd1;
      end
      default: begin
        state_n = RUN;
        hcnt_n  = '0;
      end
    endcase
  end

  // Mealy stall/flush outputs; a stalled mispredict is
  // dropped because ID operands are not final yet
  always_comb begin
    hold_active    = (state == HOLD);
    stall_now      = hold_active | load_stall
                   | br_stall[0] | br_stall[1];
    pc_write       = ~stall_now;
    ifid_write     = ~stall_now;
    idex_bubble    = stall_now;
    redirect_valid = br_mispredict & ~stall_now & ~rst;
    ifid_flush     = redirect_valid;
  end

  // Saturating stall cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (stall_now && (stall_cycles != '1))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

  // Saturating flush counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flush_count <= '0;
    else if (ifid_flush && (flush_count != '1))
      flush_count <= flush_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: vector table plus
// hand sequences for reset-in-HOLD, long hold, saturation.
module tb_stall_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       load_stall = 1'b0;
  logic [1:0] br_stall = 2'b00;
  logic       br_mispredict = 1'b0;
  logic       pc_write, ifid_write, idex_bubble;
  logic       ifid_flush, redirect_valid, hold_active;
  logic [31:0] stall_cycles, flush_count;

  logic       s_load = 1'b0;
  logic [1:0] s_br = 2'b00;
  logic       s_mp = 1'b0;
  logic       s_pw, s_iw, s_bub, s_fl, s_rv, s_hold;
  logic [3:0] s_stall, s_flush;

  stall_ctrl dut (
    .clk(clk), .rst(rst),
    .load_stall(load_stall), .br_stall(br_stall),
    .br_mispredict(br_mispredict),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .redirect_valid(redirect_valid),
    .hold_active(hold_active),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  stall_ctrl #(.BR_LOAD_STALLS(4), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst),
    .load_stall(s_load), .br_stall(s_br),
    .br_mispredict(s_mp),
    .pc_write(s_pw), .ifid_write(s_iw),
    .idex_bubble(s_bub), .ifid_flush(s_fl),
    .redirect_valid(s_rv), .hold_active(s_hold),
    .stall_cycles(s_stall), .flush_count(s_flush)
  );

  typedef struct {
    logic       rst;
    logic       ld;
    logic [1:0] br;
    logic       mp;
    logic       pw;
    logic       bub;
    logic       fl;
    logic       hold;
  } vec_t;

  vec_t vecs[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic ld,
                     input logic [1:0] br, input logic mp,
                     input logic pw, input logic bub,
                     input logic fl, input logic hold);
    vec_t v;
    v.rst = r; v.ld = ld; v.br = br; v.mp = mp;
    v.pw = pw; v.bub = bub; v.fl = fl; v.hold = hold;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_stall = 0;
  int exp_flush = 0;
  int e;

  initial begin
    // rst ld br mp | pw bub fl hold
    add(1, 0, 2'b00, 0, 1, 0, 0, 0);
    add(1, 0, 2'b00, 0, 1, 0, 0, 0);
    add(1, 1, 2'b00, 1, 0, 1, 0, 0);
    add(0, 0, 2'b00, 0, 1, 0, 0, 0);
    add(0, 1, 2'b00, 0, 0, 1, 0, 0);
    add(0, 0, 2'b00, 0, 1, 0, 0, 0);
    add(0, 0, 2'b01, 0, 0, 1, 0, 0);
    add(0, 0, 2'b00, 0, 1, 0, 0, 0);
    add(0, 0, 2'b11, 0, 0, 1, 0, 0);
    add(0, 0, 2'b00, 0, 0, 1, 0, 1);
    add(0, 0, 2'b00, 0, 1, 0, 0, 0);
    add(0, 0, 2'b10, 0, 0, 1, 0, 0);
    add(0, 0, 2'b00, 1, 0, 1, 0, 1);
    add(0, 0, 2'b00, 1, 1, 0, 1, 0);
    add(0, 0, 2'b10, 0, 0, 1, 0, 0);
    add(0, 1, 2'b00, 0, 0, 1, 0, 1);
    add(0, 0, 2'b10, 0, 0, 1, 0, 0);
    add(0, 0, 2'b00, 0, 0, 1, 0, 1);
    add(0, 1, 2'b00, 1, 0, 1, 0, 0);
    add(0, 0, 2'b00, 1, 1, 0, 1, 0);
    add(0, 0, 2'b00, 0, 1, 0, 0, 0);

    #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      load_stall = vecs[i].ld;
      br_stall = vecs[i].br;
      br_mispredict = vecs[i].mp;
      #2;
      chk($sformatf("v%0d pc_write", i), 32'(pc_write),
          32'(vecs[i].pw));
      chk($sformatf("v%0d ifid_write", i),
          32'(ifid_write), 32'(vecs[i].pw));
      chk($sformatf("v%0d idex_bubble", i),
          32'(idex_bubble), 32'(vecs[i].bub));
      chk($sformatf("v%0d ifid_flush", i),
          32'(ifid_flush), 32'(vecs[i].fl));
      chk($sformatf("v%0d redirect_valid", i),
          32'(redirect_valid), 32'(vecs[i].fl));
      chk($sformatf("v%0d hold_active", i),
          32'(hold_active), 32'(vecs[i].hold));
      if (!vecs[i].rst) begin
        if (vecs[i].bub) exp_stall++;
        if (vecs[i].fl) exp_flush++;
      end
      step();
      chk($sformatf("v%0d stall_cycles", i),
          stall_cycles, 32'(exp_stall));
      chk($sformatf("v%0d flush_count", i),
          flush_count, 32'(exp_flush));
    end

    // reset arriving mid-HOLD
    load_stall = 0; br_mispredict = 0;
    br_stall = 2'b10;
    #2;
    step();
    br_stall = 2'b00;
    #1;
    chk("rst_mid hold before", 32'(hold_active), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid hold_active", 32'(hold_active), 32'd0);
    chk("rst_mid pc_write", 32'(pc_write), 32'd1);
    chk("rst_mid stall_cycles", stall_cycles, 32'd0);
    chk("rst_mid flush_count", flush_count, 32'd0);
    step();
    rst = 1'b0;
    #2;
    chk("post_rst pc_write", 32'(pc_write), 32'd1);
    chk("post_rst hold_active", 32'(hold_active), 32'd0);
    step();
    chk("post_rst stall_cycles", stall_cycles, 32'd0);

    // four-cycle branch-on-load stall
    chk("s rst stall_cycles", 32'(s_stall), 32'd0);
    s_br = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("s bl%0d pc_write", i),
          32'(s_pw), 32'd0);
      chk($sformatf("s bl%0d hold_active", i),
          32'(s_hold), (i > 0) ? 32'd1 : 32'd0);
      step();
      s_br = 2'b00;
    end
    #2;
    chk("s bl end pc_write", 32'(s_pw), 32'd1);
    chk("s bl end hold_active", 32'(s_hold), 32'd0);
    chk("s bl stall_cycles", 32'(s_stall), 32'd4);

    // saturation at 4'hF
    s_load = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      e = (4 + i > 15) ? 15 : 4 + i;
      chk($sformatf("s sat%0d", i), 32'(s_stall), 32'(e));
    end
    s_load = 1'b0;
    step();
    step();
    chk("s sat hold", 32'(s_stall), 32'd15);
    chk("s flush_count", 32'(s_flush), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
